// File: rtl/ssp_tx_serializer.sv
// SSP transmit serializer: pops words from a first-word-fall-through FIFO and
// shifts them out MSB first behind a one-period frame sync, on a PCLK/2 serial clock.
module ssp_tx_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             PCLK,
  input  logic             CLEAR_B,
  input  logic             tx_fifo_empty,
  input  logic [WIDTH-1:0] TxData,
  output logic             read_fifo,
  output logic             SSPCLKOUT,
  output logic             SSPFSSOUT,
  output logic             SSPTXD,
  output logic             SSPOE_B,
  output logic             tx_busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PRE_LAST = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             sclk_q, sclk_d;
  logic             fss_q, fss_d;
  logic             txd_q, txd_d;
  logic             oe_b_q, oe_b_d;
  logic             launch;

  // The serial clock is high in the cycle before it falls, so that cycle's
  // rising PCLK edge is the launch edge.
  assign launch = sclk_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    sclk_d    = ~sclk_q;
    fss_d     = fss_q;
    txd_d     = txd_q;
    oe_b_d    = oe_b_q;
    read_fifo = 1'b0;

    if (launch) begin
      unique case (state_q)
        IDLE: begin
          if (!tx_fifo_empty) begin
            sh_d      = TxData;
            read_fifo = 1'b1;
            fss_d     = 1'b1;
            oe_b_d    = 1'b0;
            state_d   = SYNC;
          end
        end
        SYNC: begin
          fss_d   = 1'b0;
          txd_d   = sh_q[WIDTH-1];
          sh_d    = sh_q << 1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
        SHIFT: begin
          if (cnt_q != CNT_LAST) begin
            txd_d = sh_q[WIDTH-1];
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + 1'b1;
            // Launching bit 0: the next word's frame sync rides alongside it.
            if ((cnt_q == CNT_PRE_LAST) && !tx_fifo_empty) begin
              sh_d      = TxData;
              read_fifo = 1'b1;
              fss_d     = 1'b1;
              state_d   = SYNC;
            end
          end else begin
            txd_d   = 1'b0;
            oe_b_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      sclk_q  <= 1'b0;
      fss_q   <= 1'b0;
      txd_q   <= 1'b0;
      oe_b_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      sclk_q  <= sclk_d;
      fss_q   <= fss_d;
      txd_q   <= txd_d;
      oe_b_q  <= oe_b_d;
    end
  end

  assign SSPCLKOUT = sclk_q;
  assign SSPFSSOUT = fss_q;
  assign SSPTXD    = txd_q;
  assign SSPOE_B   = oe_b_q;
  assign tx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_ssp_tx_serializer.sv
// Directed bench for ssp_tx_serializer: FIFO model, SSP receiver model and a
// scoreboard of expected words, all stepped from one process.
module tb_ssp_tx_serializer;

  localparam int unsigned W = 8;

  logic         PCLK;
  logic         CLEAR_B;
  logic         tx_fifo_empty;
  logic [W-1:0] TxData;
  logic         read_fifo;
  logic         SSPCLKOUT;
  logic         SSPFSSOUT;
  logic         SSPTXD;
  logic         SSPOE_B;
  logic         tx_busy;

  ssp_tx_serializer #(.WIDTH(W)) dut (
    .PCLK          (PCLK),
    .CLEAR_B       (CLEAR_B),
    .tx_fifo_empty (tx_fifo_empty),
    .TxData        (TxData),
    .read_fifo     (read_fifo),
    .SSPCLKOUT     (SSPCLKOUT),
    .SSPFSSOUT     (SSPFSSOUT),
    .SSPTXD        (SSPTXD),
    .SSPOE_B       (SSPOE_B),
    .tx_busy       (tx_busy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_pass = 0;
  int n_fail = 0;

  logic [W-1:0] fifo[$];
  logic [W-1:0] exp_q[$];

  int           rx_left = 0;
  logic [W-1:0] rx_sh = '0;
  int rx_words, rd_cnt, fss_periods, oe_run, last_oe_run, overlap, toggles, oe_low_cnt;
  int rd_while_empty = 0;
  int txd_while_off  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_fifo();
    tx_fifo_empty = (fifo.size() == 0);
    TxData        = tx_fifo_empty ? '0 : fifo[0];
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fifo.push_back(w);
    exp_q.push_back(w);
    refresh_fifo();
  endtask

  task automatic clear_counts();
    rx_words = 0; rd_cnt = 0; fss_periods = 0; last_oe_run = 0;
    overlap = 0; toggles = 0; oe_low_cnt = 0;
  endtask

  // Receiver: one sample per serial period, taken mid-way through SSPCLKOUT high.
  task automatic monitor();
    logic [W-1:0] exp_w;
    if (read_fifo) rd_cnt++;
    if (read_fifo && tx_fifo_empty) rd_while_empty++;
    if (SSPOE_B && SSPTXD) txd_while_off++;
    if (SSPCLKOUT) begin
      if (!SSPOE_B) begin
        oe_run++;
        oe_low_cnt++;
      end else if (oe_run != 0) begin
        last_oe_run = oe_run;
        oe_run = 0;
      end
      if (SSPFSSOUT) fss_periods++;
      if (rx_left > 0) begin
        rx_sh = {rx_sh[W-2:0], SSPTXD};
        rx_left--;
        if (rx_left == 0) begin
          rx_words++;
          if (SSPFSSOUT) overlap++;
          if (exp_q.size() == 0) begin
            check("rx_unexpected_word", 32'(rx_sh), 32'hFFFF_FFFF);
          end else begin
            exp_w = exp_q.pop_front();
            check("rx_word", 32'(rx_sh), 32'(exp_w));
          end
        end
      end
      if (SSPFSSOUT) rx_left = W;
    end
  endtask

  task automatic tick();
    logic rf, sb;
    @(negedge PCLK);
    monitor();
    rf = read_fifo;
    sb = SSPCLKOUT;
    @(posedge PCLK);
    #1;
    if (SSPCLKOUT != sb) toggles++;
    if (rf && fifo.size() != 0) void'(fifo.pop_front());
    refresh_fifo();
  endtask

  task automatic drain();
    int n = 0;
    while ((tx_busy || exp_q.size() != 0 || fifo.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n < 400), 32'd1);
    repeat (4) tick();
  endtask

  initial begin
    int n;
    CLEAR_B = 1'b1;
    tx_fifo_empty = 1'b1;
    TxData = '0;
    oe_run = 0;
    clear_counts();
    #1 CLEAR_B = 1'b0;
    #2;
    check("reset_outputs", 32'({read_fifo, SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B, tx_busy}), 32'b000010);
    repeat (3) tick();

    // Release: first edge raises the serial clock, second edge is the first launch.
    @(negedge PCLK);
    CLEAR_B = 1'b1;
    @(posedge PCLK); #1;
    check("release_edge1_sclk", 32'(SSPCLKOUT), 32'd1);
    @(posedge PCLK); #1;
    check("release_edge2_sclk", 32'(SSPCLKOUT), 32'd0);

    // Empty FIFO for 100 PCLK.
    clear_counts();
    repeat (100) tick();
    check("empty_read_fifo", 32'(rd_cnt), 32'd0);
    check("empty_fss", 32'(fss_periods), 32'd0);
    check("empty_oe_low", 32'(oe_low_cnt), 32'd0);
    check("empty_sclk_toggles", 32'(toggles), 32'd100);

    // Single word.
    clear_counts();
    push_word(8'hA5);
    tick(); tick();
    check("latency_fss", 32'(SSPFSSOUT), 32'd1);
    drain();
    check("single_pops", 32'(rd_cnt), 32'd1);
    check("single_fss_periods", 32'(fss_periods), 32'd1);
    check("single_oe_run", 32'(last_oe_run), 32'd9);
    check("single_words", 32'(rx_words), 32'd1);
    check("single_idle", 32'({tx_busy, SSPOE_B, SSPTXD}), 32'b010);

    // Back-to-back pair.
    clear_counts();
    push_word(8'h3C);
    push_word(8'hC3);
    drain();
    check("b2b_pops", 32'(rd_cnt), 32'd2);
    check("b2b_oe_run", 32'(last_oe_run), 32'd17);
    check("b2b_fss_overlap", 32'(overlap), 32'd1);
    check("b2b_words", 32'(rx_words), 32'd2);

    // Streamed loopback.
    clear_counts();
    push_word(8'h00);
    push_word(8'hFF);
    push_word(8'h81);
    drain();
    check("stream_pops", 32'(rd_cnt), 32'd3);
    check("stream_oe_run", 32'(last_oe_run), 32'd25);
    check("stream_words", 32'(rx_words), 32'd3);

    // Reset mid-frame after bits 7..4 of 8'hFF.
    clear_counts();
    push_word(8'hFF);
    n = 0;
    while (rx_left != 4 && n < 200) begin
      tick();
      n++;
    end
    check("midframe_reach_timeout", 32'(n < 200), 32'd1);
    CLEAR_B = 1'b0;
    #1;
    check("midframe_reset_outputs", 32'({read_fifo, SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B, tx_busy}), 32'b000010);
    exp_q.delete();
    rx_left = 0;
    oe_run = 0;
    check("midframe_fifo_empty", 32'(tx_fifo_empty), 32'd1);
    repeat (3) tick();
    CLEAR_B = 1'b1;
    clear_counts();
    repeat (20) tick();
    check("midframe_no_reread", 32'(rd_cnt), 32'd0);
    check("midframe_no_words", 32'(rx_words), 32'd0);
    push_word(8'h81);
    drain();
    check("post_reset_pops", 32'(rd_cnt), 32'd1);
    check("post_reset_words", 32'(rx_words), 32'd1);

    check("read_while_empty", 32'(rd_while_empty), 32'd0);
    check("txd_while_oe_off", 32'(txd_while_off), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule

// File: doc/ssp_tx_serializer.md
SSP_TX_SERIALIZER -- requirements
Module: ssp_tx_serializer

Interface
REQ-001 SHALL have parameter: WIDTH, 8, serial frame data width in bits (MSB first).
REQ-002 SHALL have port: PCLK  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port: CLEAR_B  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: tx_fifo_empty  input  1  transmit FIFO empty flag.
REQ-005 SHALL have port: TxData  input  WIDTH  transmit FIFO head word, first-word-fall-through, valid when tx_fifo_empty=0.
REQ-006 SHALL have port: read_fifo  output  1  one-PCLK pop strobe to transmit FIFO.
REQ-007 SHALL have port: SSPCLKOUT  output  1  serial clock, PCLK/2.
REQ-008 SHALL have port: SSPFSSOUT  output  1  frame sync, high one SSPCLKOUT period before each frame's MSB.
REQ-009 SHALL have port: SSPTXD  output  1  serial data.
REQ-010 SHALL have port: SSPOE_B  output  1  active-low output enable for SSPTXD pad.
REQ-011 SHALL have port: tx_busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL be a single-clock design (PCLK); CLEAR_B asynchronous, active-low; no other clocks or resets.
REQ-013 SHALL toggle SSPCLKOUT on every PCLK rising edge (registered, no gating).
REQ-014 SHALL define a launch edge as a PCLK rising edge at which SSPCLKOUT goes 1->0; SSPTXD, SSPFSSOUT, SSPOE_B, state, bit counter change only at launch edges.
REQ-015 SHALL implement states IDLE, SYNC, SHIFT; WIDTH-bit shift register; bit counter 0..WIDTH-1, width clog2(WIDTH).
REQ-016 IDLE, launch edge, tx_fifo_empty=0: capture TxData into shift register, pulse read_fifo, SSPFSSOUT<=1, SSPOE_B<=0, go SYNC.
REQ-017 IDLE, launch edge, tx_fifo_empty=1: remain IDLE, outputs unchanged; non-launch edges ignore tx_fifo_empty.
REQ-018 SYNC, launch edge: SSPFSSOUT<=0, SSPTXD<=bit WIDTH-1, counter<=0, go SHIFT.
REQ-019 SHIFT, launch edge, counter<WIDTH-1: SSPTXD<=next lower bit, counter+1; bit k launched at counter=WIDTH-1-k.
REQ-020 SHIFT, launch edge launching bit 0 with tx_fifo_empty=0: capture TxData, pulse read_fifo, SSPFSSOUT<=1, SSPOE_B stays 0, go SYNC (back-to-back; FSS overlaps bit 0).
REQ-021 SHIFT, launch edge after bit 0 launched, no new word captured: SSPTXD<=0, SSPOE_B<=1, go IDLE.
REQ-022 read_fifo SHALL be high exactly one PCLK cycle per captured word and never while tx_fifo_empty=1.
REQ-023 Single frame SHALL occupy WIDTH+1 SSPCLKOUT periods (FSS + data); continuous stream SHALL occupy WIDTH periods per word with no idle gap.
REQ-024 Latency: first launch edge after tx_fifo_empty falls in IDLE raises SSPFSSOUT (<=2 PCLK cycles).
REQ-025 Data capture SHALL be complete at pop; TxData/tx_fifo_empty changes after pop SHALL not affect the frame in progress.
REQ-026 SSPTXD SHALL be 0 whenever SSPOE_B=1.

Reset
REQ-027 CLEAR_B low SHALL immediately force: state IDLE, counter 0, shift register 0, SSPCLKOUT 0, SSPFSSOUT 0, SSPTXD 0, SSPOE_B 1, read_fifo 0, tx_busy 0.
REQ-028 Reset mid-frame SHALL abort the frame; popped word is discarded, not re-read.
REQ-029 After CLEAR_B rises, first PCLK edge drives SSPCLKOUT to 1; first launch edge is the second PCLK edge.

Verification
REQ-030 Single word: TxData=8'hA5 in IDLE -> one read_fifo pulse, FSS one period, SSPTXD 1,0,1,0,0,1,0,1 sampled on SSPCLKOUT rising, SSPOE_B low 9 periods, then IDLE.
REQ-031 Back-to-back: FIFO holds 8'h3C, 8'hC3 -> FSS high during bit 0 of 8'h3C, 16 contiguous data bits, exactly two read_fifo pulses, SSPOE_B low continuously 17 periods.
REQ-032 Empty FIFO: tx_fifo_empty=1 for 100 PCLK -> read_fifo, SSPFSSOUT stay 0, SSPOE_B 1, SSPCLKOUT toggling.
REQ-033 Reset mid-frame: CLEAR_B low after bit 4 of 8'hFF -> all outputs at reset values same cycle; no read_fifo after release until tx_fifo_empty=0.
REQ-034 Loopback: outputs wired to matching SSP receiver, words 8'h00, 8'hFF, 8'h81 streamed -> receiver writes identical words in order.
